// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg: shared definitions for the ext_mem_lat memory model.
//   - command and access-type encodings of the MEM REQ/RESP interface
//   - size_of(): access size in bytes for a type code (0 = illegal type)
//   - mem_beat_t: one response payload as it travels down the latency pipe
package ext_mem_pkg;

  // Width of the address carried inside a beat; the top's ADDR_W must match.
  localparam int MEM_ADDR_W = 40;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_D  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;
  localparam logic [2:0] MT_WU = 3'd6;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [4:0]            cmd;
    logic [2:0]            typ;
    logic [63:0]           data;
    logic                  err;
  } mem_beat_t;

  // Access size in bytes; 0 flags the unused type code 7.
  function automatic logic [3:0] size_of(input logic [2:0] typ);
    logic [3:0] sz;
    case (typ)
      MT_B, MT_BU:  sz = 4'd1;
      MT_H, MT_HU:  sz = 4'd2;
      MT_W, MT_WU:  sz = 4'd4;
      MT_D:         sz = 4'd8;
      default:      sz = 4'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/ext_mem_lat_pipe.sv
// lat_pipe: LATENCY-deep valid + mem_beat_t shift register.
//   clk, reset     : clock, synchronous active-high flush of every stage
//   in_valid_i     : a beat enters stage 0 at this edge
//   in_beat_i      : payload entering stage 0
//   out_valid_o    : last stage holds a beat (registered)
//   out_beat_o     : last stage payload (registered, zero when empty)
//   pre_valid_o    : a beat moves into the last stage at the coming edge
module lat_pipe
  import ext_mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid_i,
  input  mem_beat_t in_beat_i,
  output logic      out_valid_o,
  output mem_beat_t out_beat_o,
  output logic      pre_valid_o
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  mem_beat_t          beat_q [LATENCY];
  mem_beat_t          beat_d [LATENCY];

  // Next-state of the shift register: stage 0 loads, every other stage shifts.
  always_comb begin
    valid_d[0] = in_valid_i;
    // Empty stages carry an all-zero payload so the outputs read 0 when idle.
    beat_d[0]  = in_valid_i ? in_beat_i : '0;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      beat_d[i]  = beat_q[i-1];
    end
  end

  // Stage registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        beat_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < LATENCY; i++) begin
        beat_q[i] <= beat_d[i];
      end
    end
  end

  assign out_valid_o = valid_q[LATENCY-1];
  assign out_beat_o  = beat_q[LATENCY-1];
  assign pre_valid_o = valid_d[LATENCY-1];

endmodule

// File: rtl/ext_mem_lat.sv
// ext_mem_lat: external memory model with configurable latency, bounded
// outstanding requests and sub-word accesses. Responses return in order.
//   clk, reset         : clock, synchronous active-high reset (storage kept)
//   mem_req_ready_o    : request can be accepted this cycle
//   mem_req_valid_i    : request valid
//   mem_req_addr_i     : byte address (word index = addr[3 +: log2(DEPTH)])
//   mem_req_cmd_i      : M_XRD / M_XWR, anything else is an erroring no-op
//   mem_req_typ_i      : access type MT_B .. MT_WU
//   mem_req_data_i     : store data, right-aligned
//   mem_resp_valid_o   : one-cycle response pulse, LATENCY cycles after accept
//   mem_resp_addr_o/cmd_o/typ_o : echoed request fields
//   mem_resp_data_o    : extended load data, 0 for writes and errors
//   mem_err_o          : misaligned / illegal access, pulses with the response
// DEPTH is expected to be a power of two; ADDR_W must equal MEM_ADDR_W.
module ext_mem_lat
  import ext_mem_pkg::*;
#(
  parameter int DEPTH           = 512,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WR_RESP         = 1,
  parameter int ADDR_W          = 40
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_ready_o,
  input  logic              mem_req_valid_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [4:0]        mem_req_cmd_i,
  input  logic [2:0]        mem_req_typ_i,
  input  logic [63:0]       mem_req_data_i,
  output logic              mem_resp_valid_o,
  output logic [ADDR_W-1:0] mem_resp_addr_o,
  output logic [4:0]        mem_resp_cmd_o,
  output logic [2:0]        mem_resp_typ_o,
  output logic [63:0]       mem_resp_data_o,
  output logic              mem_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 5;

  logic [63:0]      mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [IDX_W-1:0] idx_s;
  logic [2:0]       off_s;
  logic [3:0]       size_s;
  logic             misalign_s;
  logic             illegal_s;
  logic             err_s;
  logic [7:0]       size_lanes_s;
  logic [7:0]       byte_en_s;
  logic [63:0]      bit_mask_s;
  logic [63:0]      wdata_sh_s;
  logic [63:0]      rd_word_s;
  logic [63:0]      rd_sh_s;
  logic [63:0]      load_ext_s;
  logic [63:0]      merged_s;
  logic             accept_s;
  logic             wr_en_s;
  logic             retire_s;
  mem_beat_t        req_beat_s;
  logic             pipe_valid_s;
  mem_beat_t        pipe_beat_s;
  logic             emit_s;

  // Upper address bits beyond the index are ignored, so addresses wrap.
  assign idx_s = mem_req_addr_i[3 +: IDX_W];
  assign off_s = mem_req_addr_i[2:0];

  // Ready comes only from the registered count (and reset), never from valid.
  assign mem_req_ready_o = ~reset & (count_q < CNT_W'(MAX_OUTSTANDING));
  assign accept_s        = mem_req_valid_i & mem_req_ready_o;

  // Request decode: size, alignment, legality and byte-lane mask.
  always_comb begin
    size_s = size_of(mem_req_typ_i);
    case (mem_req_typ_i)
      MT_H, MT_HU: misalign_s = off_s[0];
      MT_W, MT_WU: misalign_s = (off_s[1:0] != 2'b00);
      MT_D:        misalign_s = (off_s != 3'b000);
      default:     misalign_s = 1'b0;
    endcase
    illegal_s = (size_s == 4'd0) ||
                ((mem_req_cmd_i != M_XRD) && (mem_req_cmd_i != M_XWR));
    err_s     = misalign_s | illegal_s;
    case (size_s)
      4'd1:    size_lanes_s = 8'h01;
      4'd2:    size_lanes_s = 8'h03;
      4'd4:    size_lanes_s = 8'h0F;
      4'd8:    size_lanes_s = 8'hFF;
      default: size_lanes_s = 8'h00;
    endcase
    byte_en_s = size_lanes_s << off_s;
    for (int i = 0; i < 8; i++) begin
      bit_mask_s[8*i +: 8] = {8{byte_en_s[i]}};
    end
  end

  // Read path and store merge; both use the word as it stands at this edge,
  // so a read after an in-flight write already sees the written data.
  always_comb begin
    rd_word_s  = mem_q[idx_s];
    rd_sh_s    = rd_word_s >> {off_s, 3'b000};
    wdata_sh_s = mem_req_data_i << {off_s, 3'b000};
    merged_s   = (rd_word_s & ~bit_mask_s) | (wdata_sh_s & bit_mask_s);
    case (mem_req_typ_i)
      MT_B:    load_ext_s = {{56{rd_sh_s[7]}},  rd_sh_s[7:0]};
      MT_H:    load_ext_s = {{48{rd_sh_s[15]}}, rd_sh_s[15:0]};
      MT_W:    load_ext_s = {{32{rd_sh_s[31]}}, rd_sh_s[31:0]};
      MT_D:    load_ext_s = rd_sh_s;
      MT_BU:   load_ext_s = {56'd0, rd_sh_s[7:0]};
      MT_HU:   load_ext_s = {48'd0, rd_sh_s[15:0]};
      MT_WU:   load_ext_s = {32'd0, rd_sh_s[31:0]};
      default: load_ext_s = 64'd0;
    endcase
  end

  // Response beat launched into the latency pipe on accept.
  always_comb begin
    req_beat_s.addr = mem_req_addr_i;
    req_beat_s.cmd  = mem_req_cmd_i;
    req_beat_s.typ  = mem_req_typ_i;
    req_beat_s.err  = err_s;
    if (!err_s && (mem_req_cmd_i == M_XRD)) begin
      req_beat_s.data = load_ext_s;
    end else begin
      req_beat_s.data = 64'd0;
    end
  end

  assign wr_en_s = accept_s & ~err_s & (mem_req_cmd_i == M_XWR);

  // Storage array: written at the accept edge, deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= merged_s;
    end
  end

  // Outstanding count: a slot stops counting once it reaches the output stage,
  // so ready returns in the very cycle its response is presented.
  always_comb begin
    case ({accept_s, retire_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Outstanding count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  lat_pipe #(
    .LATENCY (LATENCY)
  ) u_lat_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (accept_s),
    .in_beat_i   (req_beat_s),
    .out_valid_o (pipe_valid_s),
    .out_beat_o  (pipe_beat_s),
    .pre_valid_o (retire_s)
  );

  // Silent writes still travel the pipe; only their pulse is suppressed.
  assign emit_s           = (WR_RESP != 0) || (pipe_beat_s.cmd != M_XWR);
  assign mem_resp_valid_o = pipe_valid_s & emit_s;
  assign mem_err_o        = pipe_valid_s & emit_s & pipe_beat_s.err;
  assign mem_resp_addr_o  = pipe_beat_s.addr;
  assign mem_resp_cmd_o   = pipe_beat_s.cmd;
  assign mem_resp_typ_o   = pipe_beat_s.typ;
  assign mem_resp_data_o  = pipe_beat_s.data;

endmodule

// File: tb/tb_ext_mem_lat.sv
module tb_ext_mem_lat;
  import ext_mem_pkg::*;

  localparam int LAT    = 4;
  localparam int MAXO   = 2;
  localparam int DEP    = 512;
  localparam int AW     = 40;
  localparam int NW_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_ready, req_valid;
  logic [AW-1:0] req_addr;
  logic [4:0]    req_cmd;
  logic [2:0]    req_typ;
  logic [63:0]   req_data;
  logic          resp_valid, resp_err;
  logic [AW-1:0] resp_addr;
  logic [4:0]    resp_cmd;
  logic [2:0]    resp_typ;
  logic [63:0]   resp_data;

  logic          nw_ready, nw_valid;
  logic [AW-1:0] nw_addr;
  logic [4:0]    nw_cmd;
  logic [2:0]    nw_typ;
  logic [63:0]   nw_data;
  logic          nw_resp_valid, nw_err;
  logic [AW-1:0] nw_resp_addr;
  logic [4:0]    nw_resp_cmd;
  logic [2:0]    nw_resp_typ;
  logic [63:0]   nw_resp_data;

  ext_mem_lat #(.DEPTH(DEP), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .WR_RESP(1), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .mem_req_ready_o(req_ready), .mem_req_valid_i(req_valid),
    .mem_req_addr_i(req_addr), .mem_req_cmd_i(req_cmd), .mem_req_typ_i(req_typ),
    .mem_req_data_i(req_data), .mem_resp_valid_o(resp_valid), .mem_resp_addr_o(resp_addr),
    .mem_resp_cmd_o(resp_cmd), .mem_resp_typ_o(resp_typ), .mem_resp_data_o(resp_data),
    .mem_err_o(resp_err));

  ext_mem_lat #(.DEPTH(64), .LATENCY(NW_LAT), .MAX_OUTSTANDING(4), .WR_RESP(0), .ADDR_W(AW)) u_nw (
    .clk(clk), .reset(reset), .mem_req_ready_o(nw_ready), .mem_req_valid_i(nw_valid),
    .mem_req_addr_i(nw_addr), .mem_req_cmd_i(nw_cmd), .mem_req_typ_i(nw_typ),
    .mem_req_data_i(nw_data), .mem_resp_valid_o(nw_resp_valid), .mem_resp_addr_o(nw_resp_addr),
    .mem_resp_cmd_o(nw_resp_cmd), .mem_resp_typ_o(nw_resp_typ), .mem_resp_data_o(nw_resp_data),
    .mem_err_o(nw_err));

  typedef struct {
    logic [AW-1:0] addr;
    logic [4:0]    cmd;
    logic [2:0]    typ;
    logic [63:0]   data;
    logic          err;
    int            due;
  } exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_resp = 0;
  bit          mon_en = 1'b0;
  logic [63:0] last_data;
  logic        last_err;
  logic [63:0] ref_mem [DEP];
  int          acc_q [$];
  exp_t        exp_q [$];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] t);
    case (t)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      3'd3:       return 8;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] pre_val(input int w);
    return 64'h0123_4567_89AB_CDEF ^ (64'(w) * 64'h0101_0101_0101_0101);
  endfunction

  // Reference model: outstanding = accepts a with a+1 <= c <= a+LAT-1.
  task automatic model_ready(input int c, output bit rdy);
    int n = 0;
    while (acc_q.size() > 0 && acc_q[0] + LAT - 1 < c) void'(acc_q.pop_front());
    foreach (acc_q[i]) if (acc_q[i] < c) n++;
    rdy = (n < MAXO);
  endtask

  task automatic model_accept(input logic [4:0] cmd, input logic [2:0] typ,
                              input logic [AW-1:0] addr, input logic [63:0] data);
    exp_t        e;
    int          sz  = size_bytes(typ);
    int          off = int'(addr[2:0]);
    int          w   = int'((addr >> 3) % DEP);
    logic [63:0] word, val, byte_v;
    bit          err;
    err = (sz == 0) || (cmd > 5'd1) || ((off % ((sz == 0) ? 1 : sz)) != 0);
    val = 64'd0;
    if (!err && cmd == 5'd0) begin
      word = ref_mem[w];
      for (int b = 0; b < sz; b++) val |= ((word >> (8 * (off + b))) & 64'hFF) << (8 * b);
      if (typ <= 3'd2 && sz < 8 && val[8 * sz - 1]) val |= ~64'd0 << (8 * sz);
    end
    if (!err && cmd == 5'd1) begin
      word = ref_mem[w];
      for (int b = 0; b < sz; b++) begin
        byte_v = (data >> (8 * b)) & 64'hFF;
        word   = (word & ~(64'hFF << (8 * (off + b)))) | (byte_v << (8 * (off + b)));
      end
      ref_mem[w] = word;
    end
    e.addr = addr; e.cmd = cmd; e.typ = typ; e.data = val; e.err = err; e.due = cyc + LAT;
    acc_q.push_back(cyc);
    exp_q.push_back(e);
  endtask

  // One cycle of request presentation; called just after a rising edge.
  task automatic drive_req(input logic [4:0] cmd, input logic [2:0] typ, input logic [AW-1:0] addr,
                           input logic [63:0] data, output bit acc, output logic rdy);
    bit exp_rdy;
    req_valid = 1'b1; req_cmd = cmd; req_typ = typ; req_addr = addr; req_data = data;
    @(negedge clk);
    model_ready(cyc, exp_rdy);
    rdy = req_ready;
    chk("ready", {63'd0, req_ready}, {63'd0, exp_rdy});
    acc = exp_rdy;
    if (acc) model_accept(cmd, typ, addr, data);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_cycle(output logic rdy);
    bit exp_rdy;
    req_valid = 1'b0;
    @(negedge clk);
    model_ready(cyc, exp_rdy);
    rdy = req_ready;
    chk("ready_idle", {63'd0, req_ready}, {63'd0, exp_rdy});
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic [4:0] cmd, input logic [2:0] typ, input logic [AW-1:0] addr,
                        input logic [63:0] data);
    bit acc = 1'b0;
    logic rdy;
    for (int i = 0; i < 40 && !acc; i++) drive_req(cmd, typ, addr, data, acc, rdy);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request addr 0x%0h never accepted", addr);
    end
  endtask

  task automatic settle();
    logic rdy;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) idle_cycle(rdy);
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
      exp_q.delete();
    end
    idle_cycle(rdy);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL missing_resp: addr 0x%0h due cyc %0d, still absent at cyc %0d", exp_q[0].addr, exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: addr 0x%0h at cyc %0d, expected none", resp_addr, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_latency", 64'(cyc), 64'(mon_e.due));
          chk("resp_addr", 64'(resp_addr), 64'(mon_e.addr));
          chk("resp_cmd", 64'(resp_cmd), 64'(mon_e.cmd));
          chk("resp_typ", 64'(resp_typ), 64'(mon_e.typ));
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_err", 64'(resp_err), 64'(mon_e.err));
        end
        last_data = resp_data;
        last_err  = resp_err;
      end else begin
        chk("err_without_valid", 64'(resp_err), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic        rdy;
    int          n_acc, snap, pulses, pcyc, sz, off;
    logic [63:0] pdata;
    logic        perr;
    logic [5:0]  pat;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [AW-1:0] addr;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_cmd = '0; req_typ = '0; req_data = '0;
    nw_valid = 1'b0; nw_addr = '0; nw_cmd = '0; nw_typ = '0; nw_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_in_reset", 64'(req_ready), 64'd0);
    end
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_resp_addr", 64'(resp_addr), 64'd0);
    chk("rst_resp_cmd", 64'(resp_cmd), 64'd0);
    chk("rst_resp_typ", 64'(resp_typ), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Preload words 0..15 with full-word writes.
    for (int w = 0; w < 16; w++) do_req(M_XWR, MT_D, AW'(w * 8), pre_val(w));
    settle();

    // Write then read the same word back-to-back.
    do_req(M_XWR, MT_D, 40'h10, 64'h1122_3344_5566_7788);
    do_req(M_XRD, MT_D, 40'h10, 64'd0);
    settle();
    chk("wr_rd_d", last_data, 64'h1122_3344_5566_7788);

    // Byte store into the middle of the word, then loads of several widths.
    do_req(M_XWR, MT_B, 40'h13, 64'hAA);
    do_req(M_XRD, MT_D, 40'h10, 64'd0);
    settle();
    chk("byte_merge", last_data, 64'h1122_3344_AA66_7788);
    do_req(M_XRD, MT_B, 40'h13, 64'd0);
    settle();
    chk("load_b_sext", last_data, 64'hFFFF_FFFF_FFFF_FFAA);
    do_req(M_XRD, MT_BU, 40'h13, 64'd0);
    settle();
    chk("load_bu_zext", last_data, 64'h0000_0000_0000_00AA);

    // Valid held high for 6 cycles against MAX_OUTSTANDING=2.
    pat = 6'b110011;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(M_XRD, MT_D, AW'(8 * (4 + n_acc)), 64'd0, acc, rdy);
      chk("ready_pattern", 64'(rdy), 64'(pat[5 - i]));
      if (acc) n_acc++;
    end
    settle();
    chk("accept_count", 64'(n_acc), 64'd4);

    // Misaligned halfword read and write.
    do_req(M_XRD, MT_H, 40'h11, 64'd0);
    settle();
    chk("misalign_rd_data", last_data, 64'd0);
    chk("misalign_rd_err", 64'(last_err), 64'd1);
    do_req(M_XWR, MT_H, 40'h11, 64'hBEEF);
    do_req(M_XRD, MT_D, 40'h10, 64'd0);
    settle();
    chk("misalign_no_store", last_data, 64'h1122_3344_AA66_7788);

    // Reset with reads in flight.
    do_req(M_XRD, MT_D, 40'h18, 64'd0);
    do_req(M_XRD, MT_D, 40'h20, 64'd0);
    drive_req(M_XRD, MT_D, 40'h28, 64'd0, acc, rdy);
    chk("third_read_stalled", 64'(acc), 64'd0);
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    snap = n_resp;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle(rdy);
    chk("ready_after_reset", 64'(rdy), 64'd1);
    for (int i = 0; i < 8; i++) idle_cycle(rdy);
    chk("no_resp_after_reset", 64'(n_resp), 64'(snap));
    do_req(M_XRD, MT_D, 40'h38, 64'd0);
    settle();
    chk("preload_survives", last_data, pre_val(7));

    // Randomized traffic over the preloaded words with wrapping upper bits.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        idle_cycle(rdy);
      end else begin
        case ($urandom_range(0, 9))
          0:       cmd = 5'($urandom_range(2, 31));
          1, 2, 3, 4: cmd = M_XWR;
          default: cmd = M_XRD;
        endcase
        typ = 3'($urandom_range(0, 7));
        sz  = size_bytes(typ);
        if (sz > 0 && $urandom_range(0, 9) < 7) off = $urandom_range(0, 8 / sz - 1) * sz;
        else off = $urandom_range(0, 7);
        addr = {28'($urandom), 5'd0, 4'($urandom_range(0, 15)), 3'(off)};
        drive_req(cmd, typ, addr, {$urandom, $urandom}, acc, rdy);
      end
    end
    settle();

    // Silent writes: a write followed by a read yields a single pulse.
    @(posedge clk); #1;
    pulses = 0; pcyc = -1; pdata = '0; perr = 1'b0;
    snap = cyc;
    nw_valid = 1'b1; nw_cmd = M_XWR; nw_typ = MT_D; nw_addr = 40'h28; nw_data = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    chk("nw_ready_wr", 64'(nw_ready), 64'd1);
    if (nw_resp_valid) begin pulses++; pcyc = cyc; end
    @(posedge clk); #1;
    nw_cmd = M_XRD; nw_data = 64'd0;
    @(negedge clk);
    chk("nw_ready_rd", 64'(nw_ready), 64'd1);
    if (nw_resp_valid) begin pulses++; pcyc = cyc; end
    @(posedge clk); #1;
    nw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (nw_resp_valid) begin
        pulses++; pcyc = cyc; pdata = nw_resp_data; perr = nw_err;
      end
    end
    chk("nw_pulse_count", 64'(pulses), 64'd1);
    chk("nw_pulse_cycle", 64'(pcyc), 64'(snap + 1 + NW_LAT));
    chk("nw_read_data", pdata, 64'hCAFE_F00D_1234_5678);
    chk("nw_read_err", 64'(perr), 64'd0);
    chk("nw_ready_end", 64'(nw_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
